// File: rtl/cp0_unit.sv
// Coprocessor 0 for the 5-stage MIPS pipeline, located in the M stage.
// Holds SR, Cause, EPC and PRId and services mfc0, mtc0 and eret.
// External interrupts and M-stage exceptions are merged into a single Req.
// When Req is high, every pipeline register is flushed and the PC is
// redirected to HandlerPC.
module cp0_unit #(
  parameter logic [31:0] PRID         = 32'h2023_0707,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic [31:0] HandlerPC,
  output logic        Req
);

  localparam logic [4:0] A_SR    = 5'd12;
  localparam logic [4:0] A_CAUSE = 5'd13;
  localparam logic [4:0] A_EPC   = 5'd14;
  localparam logic [4:0] A_PRID  = 5'd15;

  // SR fields
  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  // Cause fields
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  // EPC
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_wr_sr;
  logic        w_wr_epc;
  logic [31:0] w_vpc_word;
  logic [31:0] w_epc_next;
  logic        w_unused;

  // Request arbitration: interrupts are masked by IM/IE, and EXL blocks everything.
  always_comb begin
    w_int_req = (|(HWInt & r_im)) & r_ie & ~r_exl;
    w_exc_req = (ExcCodeIn != 5'd0) & ~r_exl;
  end

  assign Req       = w_int_req | w_exc_req;
  assign HandlerPC = HANDLER_ADDR;
  assign EPCOut    = r_epc;

  // mtc0 decode. A taken request cancels the M instruction, so its write is dropped.
  assign w_wr_sr  = en & ~Req & (CP0Add == A_SR);
  assign w_wr_epc = en & ~Req & (CP0Add == A_EPC);

  // Victim PC, word-aligned. A delay-slot victim restarts at its branch.
  assign w_vpc_word = {VPC[31:2], 2'b00};
  assign w_epc_next = BDIn ? (w_vpc_word - 32'd4) : w_vpc_word;

  // The low two PC bits are discarded by design.
  assign w_unused = ^VPC[1:0];

  // SR update. When eret and mtc0 SR occur together, the mtc0 value is written
  // last, so it sets the final EXL value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_im  <= 6'd0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
    end else if (Req) begin
      r_exl <= 1'b1;
    end else begin
      if (EXLClr) r_exl <= 1'b0;
      if (w_wr_sr) begin
        r_im  <= CP0In[15:10];
        r_exl <= CP0In[1];
        r_ie  <= CP0In[0];
      end
    end
  end

  // Cause update. IP samples the interrupt lines every cycle.
  // BD and ExcCode change only when a request is taken.
  // Cause is not software-writable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bd      <= 1'b0;
      r_ip      <= 6'd0;
      r_exccode <= 5'd0;
    end else begin
      r_ip <= HWInt;
      if (Req) begin
        r_bd      <= BDIn;
        r_exccode <= w_int_req ? 5'd0 : ExcCodeIn;
      end
    end
  end

  // EPC update. A taken request captures the victim PC;
  // otherwise mtc0 writes a word-aligned value.
  always_ff @(posedge clk) begin
    if (reset)         r_epc <= 32'd0;
    else if (Req)      r_epc <= w_epc_next;
    else if (w_wr_epc) r_epc <= {CP0In[31:2], 2'b00};
  end

  // mfc0 read mux. It shows register contents from before the current edge.
  always_comb begin
    CP0Out = 32'd0;
    case (CP0Add)
      A_SR:    CP0Out = {16'd0, r_im, 8'd0, r_exl, r_ie};
      A_CAUSE: CP0Out = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};
      A_EPC:   CP0Out = r_epc;
      A_PRID:  CP0Out = PRID;
      default: CP0Out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Testbench for cp0_unit.
// The reference model keeps SR, Cause and EPC as whole 32-bit words
// and derives every expected value from the architectural rules.
module tb_cp0_unit;
  localparam logic [31:0] PRID    = 32'h2023_0707;
  localparam logic [31:0] HANDLER = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset, en, BDIn, EXLClr, Req;
  logic [4:0]  CP0Add, ExcCodeIn;
  logic [31:0] CP0In, CP0Out, VPC, EPCOut, HandlerPC;
  logic [5:0]  HWInt;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] m_sr, m_cause, m_epc;

  cp0_unit #(.PRID(PRID), .HANDLER_ADDR(HANDLER)) dut (
    .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In),
    .CP0Out(CP0Out), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
    .HWInt(HWInt), .EXLClr(EXLClr), .EPCOut(EPCOut), .HandlerPC(HandlerPC),
    .Req(Req)
  );

  always #5 clk = ~clk;

  function automatic logic m_ireq();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_ireq() || ((ExcCodeIn != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  // Advance one clock edge and apply the architectural rules to the model.
  task automatic cyc();
    logic [31:0] ns, ne;
    logic bd;
    logic [4:0] code;
    if (reset) begin
      ns = 0; ne = 0; bd = 0; code = 0;
    end else begin
      ns = m_sr; ne = m_epc; bd = m_cause[31]; code = m_cause[6:2];
      if (m_req()) begin
        ns = ns | 32'h2;
        bd = BDIn;
        code = m_ireq() ? 5'd0 : ExcCodeIn;
        ne = (VPC & 32'hFFFF_FFFC) - (BDIn ? 32'd4 : 32'd0);
      end else begin
        if (EXLClr) ns = ns & ~32'h2;
        if (en && CP0Add == 5'd12) ns = CP0In & 32'h0000_FC03;
        if (en && CP0Add == 5'd14) ne = CP0In & 32'hFFFF_FFFC;
      end
    end
    @(posedge clk);
    #1;
    m_sr = ns;
    m_epc = ne;
    m_cause = reset ? 32'd0 : (({31'd0, bd} << 31) | ({26'd0, HWInt} << 10) | ({27'd0, code} << 2));
  endtask

  task automatic idle();
    en = 0; CP0Add = 0; CP0In = 0; VPC = 0; BDIn = 0; ExcCodeIn = 0; EXLClr = 0;
  endtask

  task automatic test_reset();
    logic [5:0] hw;
    hw = 6'($urandom_range(1, 63));
    reset = 1; idle(); HWInt = hw;
    cyc(); cyc();
    reset = 0;
    cyc();
    #1;
    n_chk++; if (Req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", Req); end
    n_chk++; if (EPCOut !== 32'd0) begin n_fail++; $display("FAIL reset_epcout got=%h exp=0", EPCOut); end
    n_chk++; if (HandlerPC !== HANDLER) begin n_fail++; $display("FAIL handler_pc got=%h exp=%h", HandlerPC, HANDLER); end
    CP0Add = 12; #1;
    n_chk++; if (CP0Out !== 32'd0) begin n_fail++; $display("FAIL reset_sr got=%h exp=0", CP0Out); end
    CP0Add = 13; #1;
    n_chk++; if (CP0Out !== {16'd0, hw, 10'd0}) begin n_fail++; $display("FAIL reset_cause got=%h exp=%h", CP0Out, {16'd0, hw, 10'd0}); end
    CP0Add = 14; #1;
    n_chk++; if (CP0Out !== 32'd0) begin n_fail++; $display("FAIL reset_epc got=%h exp=0", CP0Out); end
    CP0Add = 15; #1;
    n_chk++; if (CP0Out !== 32'h2023_0707) begin n_fail++; $display("FAIL prid got=%h exp=20230707", CP0Out); end
    CP0Add = 3; #1;
    n_chk++; if (CP0Out !== 32'd0) begin n_fail++; $display("FAIL unmapped got=%h exp=0", CP0Out); end
  endtask

  task automatic test_mtc0_sr();
    HWInt = 0; idle();
    en = 1; CP0Add = 12; CP0In = 32'hFFFF_FFFF;
    cyc();
    en = 0; #1;
    n_chk++; if (CP0Out !== 32'h0000_FC03) begin n_fail++; $display("FAIL mtc0_sr got=%h exp=0000fc03", CP0Out); end
    // Restore SR to zero.
    en = 1; CP0In = 0; cyc(); en = 0; #1;
    n_chk++; if (CP0Out !== 32'd0) begin n_fail++; $display("FAIL mtc0_sr_clr got=%h exp=0", CP0Out); end
  endtask

  task automatic test_mtc0_cause();
    logic [5:0] hw;
    hw = 6'($urandom);
    HWInt = hw; idle();
    en = 1; CP0Add = 13; CP0In = 32'hFFFF_FFFF;
    cyc();
    en = 0; #1;
    n_chk++; if (CP0Out !== {16'd0, hw, 10'd0}) begin n_fail++; $display("FAIL mtc0_cause got=%h exp=%h", CP0Out, {16'd0, hw, 10'd0}); end
    HWInt = 0;
    cyc();
  endtask

  task automatic test_overflow();
    idle(); HWInt = 0;
    ExcCodeIn = 12; VPC = 32'h0000_3008; BDIn = 0; #1;
    n_chk++; if (Req !== 1'b1) begin n_fail++; $display("FAIL ov_req got=%b exp=1", Req); end
    n_chk++; if (HandlerPC !== 32'h0000_4180) begin n_fail++; $display("FAIL ov_handler got=%h exp=00004180", HandlerPC); end
    cyc();
    #1;
    n_chk++; if (EPCOut !== 32'h0000_3008) begin n_fail++; $display("FAIL ov_epc got=%h exp=00003008", EPCOut); end
    n_chk++; if (Req !== 1'b0) begin n_fail++; $display("FAIL ov_req_after got=%b exp=0", Req); end
    ExcCodeIn = 0; CP0Add = 13; #1;
    n_chk++; if (CP0Out !== 32'h0000_0030) begin n_fail++; $display("FAIL ov_cause got=%h exp=00000030", CP0Out); end
    CP0Add = 12; #1;
    n_chk++; if (CP0Out !== 32'h0000_0002) begin n_fail++; $display("FAIL ov_exl got=%h exp=00000002", CP0Out); end
    EXLClr = 1; cyc(); EXLClr = 0;
  endtask

  task automatic test_dslot_int();
    idle(); HWInt = 0;
    en = 1; CP0Add = 12; CP0In = 32'h0000_0401; cyc(); idle();
    HWInt = 6'b000001; BDIn = 1; VPC = 32'h0000_3010; #1;
    n_chk++; if (Req !== 1'b1) begin n_fail++; $display("FAIL ds_req got=%b exp=1", Req); end
    cyc();
    BDIn = 0; VPC = 0; #1;
    n_chk++; if (EPCOut !== 32'h0000_300C) begin n_fail++; $display("FAIL ds_epc got=%h exp=0000300c", EPCOut); end
    CP0Add = 13; #1;
    n_chk++; if (CP0Out !== 32'h8000_0400) begin n_fail++; $display("FAIL ds_cause got=%h exp=80000400", CP0Out); end
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (Req !== 1'b0) begin n_fail++; $display("FAIL ds_hold[%0d] got=%b exp=0", i, Req); end
      cyc();
    end
    EXLClr = 1; #1;
    n_chk++; if (Req !== 1'b0) begin n_fail++; $display("FAIL ds_eret_req got=%b exp=0", Req); end
    cyc();
    EXLClr = 0; #1;
    n_chk++; if (Req !== 1'b1) begin n_fail++; $display("FAIL ds_rereq got=%b exp=1", Req); end
    cyc();
    HWInt = 0; EXLClr = 1; cyc(); EXLClr = 0;
  endtask

  task automatic test_simul();
    idle(); HWInt = 0;
    en = 1; CP0Add = 14; CP0In = 32'h0000_5000; ExcCodeIn = 10; VPC = 32'h0000_3020; #1;
    n_chk++; if (Req !== 1'b1) begin n_fail++; $display("FAIL sim_req got=%b exp=1", Req); end
    cyc();
    idle(); #1;
    n_chk++; if (EPCOut !== 32'h0000_3020) begin n_fail++; $display("FAIL sim_epc got=%h exp=00003020", EPCOut); end
    EXLClr = 1; cyc(); EXLClr = 0;
  endtask

  task automatic test_reset_mid_handler();
    idle(); HWInt = 0;
    en = 1; CP0Add = 12; CP0In = 32'h0000_FC01; cyc(); idle();
    HWInt = 6'b100000; cyc();
    reset = 1; cyc(); reset = 0; #1;
    n_chk++; if (Req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req got=%b exp=0", Req); end
    cyc(); #1;
    n_chk++; if (Req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req2 got=%b exp=0", Req); end
    HWInt = 0;
  endtask

  task automatic test_random();
    logic [4:0] adds [6];
    adds = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd31};
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 49) == 0);
      en        = ($urandom_range(0, 2) == 0);
      CP0Add    = adds[$urandom_range(0, 5)];
      CP0In     = $urandom;
      VPC       = $urandom;
      BDIn      = 1'($urandom);
      ExcCodeIn = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      HWInt     = 6'($urandom);
      EXLClr    = ($urandom_range(0, 3) == 0);
      #1;
      n_chk++; if (Req !== m_req()) begin n_fail++; $display("FAIL rnd_req[%0d] got=%b exp=%b", i, Req, m_req()); end
      n_chk++; if (CP0Out !== m_read(CP0Add)) begin n_fail++; $display("FAIL rnd_out[%0d] a=%0d got=%h exp=%h", i, CP0Add, CP0Out, m_read(CP0Add)); end
      n_chk++; if (EPCOut !== m_epc) begin n_fail++; $display("FAIL rnd_epc[%0d] got=%h exp=%h", i, EPCOut, m_epc); end
      cyc();
    end
    reset = 0; idle();
  endtask

  initial begin
    m_sr = 0; m_cause = 0; m_epc = 0;
    HWInt = 0; reset = 1; idle();
    test_reset();
    test_mtc0_sr();
    test_mtc0_cause();
    test_overflow();
    test_dslot_int();
    test_simul();
    test_reset_mid_handler();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor 0 of the 5-stage MIPS pipeline; sits in the M stage beside data memory.
- Holds SR, Cause, EPC and PRId, and services mfc0/mtc0/eret.
- Arbitrates exceptions and external interrupts into a single Req.
- Req flushes all pipeline registers (including the M/W register) and redirects the PC to the handler. CP0Out is the value latched into the M/W register for mfc0 writeback.

Parameters:
- PRID, 32'h2023_0707, read-only value returned for register 15.
- HANDLER_ADDR, 32'h0000_4180, exception entry address driven on HandlerPC.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- en  input  1  mtc0 write enable (M-stage instruction is mtc0)
- CP0Add  input  5  register number for mfc0/mtc0 (rd field)
- CP0In  input  32  mtc0 write data (forwarded rt value)
- CP0Out  output  32  mfc0 read data, combinational
- VPC  input  32  PC of the instruction currently in M (victim PC)
- BDIn  input  1  M instruction is in a branch delay slot
- ExcCodeIn  input  5  pipelined exception code of the M instruction; 0 = none
- HWInt  input  6  external interrupt lines, level-sensitive
- EXLClr  input  1  eret is in M
- EPCOut  output  32  current EPC register, for eret target
- HandlerPC  output  32  constant HANDLER_ADDR
- Req  output  1  take exception/interrupt this cycle, combinational

Behaviour:
- Register fields:
  - SR(12): IM = bit[15:10], EXL = bit[1], IE = bit[0]; all other bits read 0.
  - Cause(13): BD = bit[31], IP = bit[15:10], ExcCode = bit[6:2]; all other bits read 0.
  - EPC(14): full 32 bits.
  - PRId(15): constant PRID.
- Reset (sync, highest priority): SR = 0, Cause = 0, EPC = 0. Outputs that follow from this: EPCOut = 0, Req = 0, CP0Out = 0 for addresses other than 15.
- Req logic (combinational):
  - IntReq = (|(HWInt & IM)) & IE & ~EXL.
  - ExcReq = (ExcCodeIn != 0) & ~EXL.
  - Req = IntReq | ExcReq.
  - Interrupt has priority over exception.
- Cause.IP is written with HWInt every non-reset cycle, independent of all other events.
- Sequential update at posedge when Req = 1 (reset = 0):
  - EXL <= 1.
  - Cause.BD <= BDIn.
  - Cause.ExcCode <= IntReq ? 5'd0 : ExcCodeIn.
  - EPC <= BDIn ? {VPC[31:2],2'b00} - 4 : {VPC[31:2],2'b00}.
  - mtc0 and EXLClr in the same cycle are ignored, since the victim instruction is cancelled.
- When Req = 0:
  - EXLClr = 1 sets EXL <= 0.
  - en = 1 writes CP0In into the register selected by CP0Add:
    - SR: only IM/EXL/IE bits are stored.
    - EPC: {CP0In[31:2],2'b00}.
    - Cause, PRId and unmapped addresses: no effect.
  - If EXLClr and mtc0 to SR occur in the same cycle, the mtc0 value wins for EXL (they cannot coexist legally; this is the deterministic tie-break).
- CP0Out: combinational mux on CP0Add over 12/13/14/15; any other address returns 0. The value reflects register contents before the current edge (no internal write bypass).
- EPCOut = EPC register. A following eret sees an mtc0 EPC write one cycle later; the hazard unit stalls eret in D while mtc0 to EPC is in E or M.
- Latency:
  - Req is asserted in the same cycle the condition is present.
  - Register effects are visible on the next cycle.
  - With EXL = 1, no further Req is raised until EXLClr, regardless of pending HWInt.
- Reset mid-handler clears EXL and IE. A pending HWInt then does not raise Req until IE is set again.

Test Plan:
- Reset then mfc0 sweep:
  - CP0Add = 12/13/14/15/3 -> CP0Out = 0 / {16'b0,IP=HWInt sampled,10'b0} / 0 / 32'h2023_0707 / 0.
- mtc0 SR with CP0In = 32'hFFFF_FFFF -> next cycle CP0Out(12) = 32'h0000_FC03.
- mtc0 Cause with 32'hFFFF_FFFF -> Cause.IP only tracks HWInt; BD and ExcCode stay 0.
- Overflow exception:
  - Stimulus: ExcCodeIn = 5'd12, VPC = 32'h0000_3008, BDIn = 0, EXL = 0.
  - Same cycle: Req = 1, HandlerPC = 32'h0000_4180.
  - Next cycle: EPC = 32'h3008, ExcCode = 12, EXL = 1, Req = 0.
- Delay-slot interrupt:
  - Stimulus: SR = 32'h0000_0401, HWInt = 6'b000001, BDIn = 1, VPC = 32'h0000_3010.
  - Required: Req = 1; EPC = 32'h300C, BD = 1, ExcCode = 0.
  - With HWInt held: Req stays 0 while EXL = 1.
  - Then EXLClr pulse -> EXL = 0, and Req reasserts the following cycle.
- Simultaneous mtc0 EPC (en = 1, CP0In = 32'h5000) with ExcCodeIn = 5'd10, VPC = 32'h3020:
  - Required: EPC = 32'h3020; the mtc0 write is dropped.
